sat_bin_loader: RTL and testbench

- Upstream sequencer for sat_engine.
- On a start command it fetches the NUM_CLAUSES clause words of one bin from clause memory, one read at a time, and writes each into the engine's clause array. It then writes the bin's variable-state and level-state vectors and pulses start_core.
- It then waits for done_core and captures sat/unsat/bkt_lvl/cur_lvl for the bin manager.
- It replaces the directed load sequence used when the engine is exercised standalone.

---
 rtl/sat_bin_loader.sv | 183 ++++++++++++++++++
 tb/tb_sat_bin_loader.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sat_bin_loader.sv
// Bin loader sequencing clause fetches from clause memory into the sat_engine,
// then loading state vectors, starting the engine and capturing its result.
module sat_bin_loader #(
  parameter int NUM_CLAUSES      = 8,
  parameter int NUM_VARS         = 8,
  parameter int NUM_LVLS         = 8,
  parameter int WIDTH_BIN_ID     = 10,
  parameter int WIDTH_LVL        = 16,
  parameter int WIDTH_VAR_STATES = 19,
  parameter int WIDTH_LVL_STATES = 11,
  parameter int WIDTH_CIDX       = $clog2(NUM_CLAUSES)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start_i,
  input  logic [WIDTH_BIN_ID-1:0]                bin_id_i,
  input  logic [WIDTH_LVL-1:0]                   load_lvl_i,
  input  logic [WIDTH_LVL-1:0]                   base_lvl_i,
  input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vs_bin_i,
  input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   ls_bin_i,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic                                   sat_o,
  output logic                                   unsat_o,
  output logic [WIDTH_LVL-1:0]                   bkt_lvl_o,
  output logic [WIDTH_LVL-1:0]                   cur_lvl_o,
  output logic                                   cmem_rd_o,
  output logic [WIDTH_BIN_ID+WIDTH_CIDX-1:0]     cmem_addr_o,
  input  logic [NUM_VARS*3-1:0]                  cmem_data_i,
  input  logic                                   cmem_valid_i,
  output logic [NUM_CLAUSES-1:0]                 wr_carray_o,
  output logic [NUM_VARS*3-1:0]                  clause_o,
  output logic [NUM_VARS-1:0]                    wr_var_states_o,
  output logic [WIDTH_VAR_STATES*NUM_VARS-1:0]   vars_states_o,
  output logic [NUM_LVLS-1:0]                    wr_lvl_states_o,
  output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]   lvl_states_o,
  output logic                                   start_core_o,
  output logic [WIDTH_LVL-1:0]                   cur_bin_num_o,
  output logic [WIDTH_LVL-1:0]                   load_lvl_o,
  output logic                                   base_lvl_en_o,
  output logic [WIDTH_LVL-1:0]                   base_lvl_o,
  input  logic                                   done_core_i,
  input  logic                                   sat_i,
  input  logic                                   unsat_i,
  input  logic [WIDTH_LVL-1:0]                   bkt_lvl_i,
  input  logic [WIDTH_LVL-1:0]                   cur_lvl_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_VS, S_WR_LS, S_START, S_RUN, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH_CIDX-1:0]                 idx;
  logic [WIDTH_BIN_ID-1:0]               bin_id_q;
  logic [WIDTH_LVL-1:0]                  load_lvl_q;
  logic [WIDTH_LVL-1:0]                  base_lvl_q;
  logic [WIDTH_VAR_STATES*NUM_VARS-1:0]  vs_q;
  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0]  ls_q;
  logic                                  eng_drive;
  logic                                  last_clause;

  assign last_clause = (idx == WIDTH_CIDX'(NUM_CLAUSES - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: next state defaults to the current state before the case so no
  // path through the block leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:    if (start_i) state_nxt = S_RD_REQ;
      S_RD_REQ:  state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (cmem_valid_i) state_nxt = last_clause ? S_WR_VS : S_RD_REQ;
      S_WR_VS:   state_nxt = S_WR_LS;
      S_WR_LS:   state_nxt = S_START;
      S_START:   state_nxt = S_RUN;
      S_RUN:     if (done_core_i) state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Strobe and address come straight from the state so the read issues
  // in the same cycle the FSM enters RD_REQ.
  assign cmem_rd_o   = (state == S_RD_REQ);
  assign cmem_addr_o = cmem_rd_o ? {bin_id_q, idx} : '0;
  assign busy_o      = (state != S_IDLE) && (state != S_DONE);
  assign done_o      = (state == S_DONE);

  assign cur_bin_num_o = eng_drive ? WIDTH_LVL'(bin_id_q) : '0;
  assign load_lvl_o    = eng_drive ? load_lvl_q : '0;
  assign base_lvl_o    = eng_drive ? base_lvl_q : '0;

  // Engine-side write pulses are registered: each appears in the cycle after
  // the state that requests it, keeping the clause write ahead of WR_VS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx             <= '0;
      bin_id_q        <= '0;
      load_lvl_q      <= '0;
      base_lvl_q      <= '0;
      vs_q            <= '0;
      ls_q            <= '0;
      eng_drive       <= 1'b0;
      sat_o           <= 1'b0;
      unsat_o         <= 1'b0;
      bkt_lvl_o       <= '0;
      cur_lvl_o       <= '0;
      wr_carray_o     <= '0;
      clause_o        <= '0;
      wr_var_states_o <= '0;
      vars_states_o   <= '0;
      wr_lvl_states_o <= '0;
      lvl_states_o    <= '0;
      start_core_o    <= 1'b0;
      base_lvl_en_o   <= 1'b0;
    end else begin
      wr_carray_o     <= '0;
      clause_o        <= '0;
      wr_var_states_o <= '0;
      vars_states_o   <= '0;
      wr_lvl_states_o <= '0;
      lvl_states_o    <= '0;
      start_core_o    <= 1'b0;
      base_lvl_en_o   <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            bin_id_q   <= bin_id_i;
            load_lvl_q <= load_lvl_i;
            base_lvl_q <= base_lvl_i;
            vs_q       <= vs_bin_i;
            ls_q       <= ls_bin_i;
            idx        <= '0;
            sat_o      <= 1'b0;
            unsat_o    <= 1'b0;
            bkt_lvl_o  <= '0;
            cur_lvl_o  <= '0;
          end
        end
        S_RD_WAIT: begin
          if (cmem_valid_i) begin
            wr_carray_o <= NUM_CLAUSES'(1) << idx;
            clause_o    <= cmem_data_i;
            if (!last_clause) idx <= idx + WIDTH_CIDX'(1);
          end
        end
        S_WR_VS: begin
          wr_var_states_o <= '1;
          vars_states_o   <= vs_q;
        end
        S_WR_LS: begin
          wr_lvl_states_o <= '1;
          lvl_states_o    <= ls_q;
        end
        S_START: begin
          start_core_o  <= 1'b1;
          base_lvl_en_o <= 1'b1;
          eng_drive     <= 1'b1;
        end
        S_RUN: begin
          if (done_core_i) begin
            sat_o     <= sat_i;
            unsat_o   <= unsat_i;
            bkt_lvl_o <= bkt_lvl_i;
            cur_lvl_o <= cur_lvl_i;
            eng_drive <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sat_bin_loader.sv
// Self-checking bench for sat_bin_loader: acts as clause memory and engine,
// checks addresses, row writes, pulse spacing and captured results.
module tb_sat_bin_loader;

  localparam int NUM_CLAUSES      = 8;
  localparam int NUM_VARS         = 8;
  localparam int NUM_LVLS         = 8;
  localparam int WIDTH_BIN_ID     = 10;
  localparam int WIDTH_LVL        = 16;
  localparam int WIDTH_VAR_STATES = 19;
  localparam int WIDTH_LVL_STATES = 11;
  localparam int WIDTH_CIDX       = 3;
  localparam int CW  = NUM_VARS * 3;
  localparam int VSW = WIDTH_VAR_STATES * NUM_VARS;
  localparam int LSW = WIDTH_LVL_STATES * NUM_LVLS;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic                          start_i = 1'b0;
  logic [WIDTH_BIN_ID-1:0]       bin_id_i = '0;
  logic [WIDTH_LVL-1:0]          load_lvl_i = '0, base_lvl_i = '0;
  logic [VSW-1:0]                vs_bin_i = '0;
  logic [LSW-1:0]                ls_bin_i = '0;
  logic                          busy_o, done_o, sat_o, unsat_o;
  logic [WIDTH_LVL-1:0]          bkt_lvl_o, cur_lvl_o;
  logic                          cmem_rd_o;
  logic [WIDTH_BIN_ID+WIDTH_CIDX-1:0] cmem_addr_o;
  logic [CW-1:0]                 cmem_data_i = '0;
  logic                          cmem_valid_i = 1'b0;
  logic [NUM_CLAUSES-1:0]        wr_carray_o;
  logic [CW-1:0]                 clause_o;
  logic [NUM_VARS-1:0]           wr_var_states_o;
  logic [VSW-1:0]                vars_states_o;
  logic [NUM_LVLS-1:0]           wr_lvl_states_o;
  logic [LSW-1:0]                lvl_states_o;
  logic                          start_core_o, base_lvl_en_o;
  logic [WIDTH_LVL-1:0]          cur_bin_num_o, load_lvl_o, base_lvl_o;
  logic                          done_core_i = 1'b0, sat_i = 1'b0, unsat_i = 1'b0;
  logic [WIDTH_LVL-1:0]          bkt_lvl_i = '0, cur_lvl_i = '0;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [CW-1:0] mem [NUM_CLAUSES];

  always #5 clk = ~clk;

  sat_bin_loader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .bin_id_i(bin_id_i),
    .load_lvl_i(load_lvl_i), .base_lvl_i(base_lvl_i), .vs_bin_i(vs_bin_i),
    .ls_bin_i(ls_bin_i), .busy_o(busy_o), .done_o(done_o), .sat_o(sat_o),
    .unsat_o(unsat_o), .bkt_lvl_o(bkt_lvl_o), .cur_lvl_o(cur_lvl_o),
    .cmem_rd_o(cmem_rd_o), .cmem_addr_o(cmem_addr_o), .cmem_data_i(cmem_data_i),
    .cmem_valid_i(cmem_valid_i), .wr_carray_o(wr_carray_o), .clause_o(clause_o),
    .wr_var_states_o(wr_var_states_o), .vars_states_o(vars_states_o),
    .wr_lvl_states_o(wr_lvl_states_o), .lvl_states_o(lvl_states_o),
    .start_core_o(start_core_o), .cur_bin_num_o(cur_bin_num_o),
    .load_lvl_o(load_lvl_o), .base_lvl_en_o(base_lvl_en_o),
    .base_lvl_o(base_lvl_o), .done_core_i(done_core_i), .sat_i(sat_i),
    .unsat_i(unsat_i), .bkt_lvl_i(bkt_lvl_i), .cur_lvl_i(cur_lvl_i)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every output folded into one bit each; all must be zero after reset.
  task automatic check_quiet(input string tag);
    check(tag, 256'({busy_o, done_o, sat_o, unsat_o, cmem_rd_o, start_core_o,
                     base_lvl_en_o, |wr_carray_o, |clause_o, |wr_var_states_o,
                     |vars_states_o, |wr_lvl_states_o, |lvl_states_o, |bkt_lvl_o,
                     |cur_lvl_o, |cmem_addr_o, |cur_bin_num_o, |load_lvl_o,
                     |base_lvl_o}), 256'(0));
  endtask

  // One load-and-solve job. The bench plays clause memory (latency 0..max_lat
  // extra cycles) and engine (done after done_dly cycles from start_core).
  task automatic run_job(input int bin, input bit a5, input int max_lat,
                         input bit noise, input int abort_at,
                         input bit e_sat, input bit e_unsat,
                         input logic [15:0] e_bkt, input logic [15:0] e_cur,
                         input int done_dly);
    logic [VSW-1:0] vs;
    logic [LSW-1:0] ls;
    logic [15:0]    ll, bl;
    int  rd_cnt, wr_cnt, cd, last_wr, t_start, n_start;
    bit  pend, finished;

    vs = VSW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
    ls = LSW'({$urandom(), $urandom(), $urandom()});
    ll = 16'($urandom());
    bl = 16'($urandom());
    for (int i = 0; i < NUM_CLAUSES; i++)
      mem[i] = a5 ? CW'(24'hA5A5A5 + i) : CW'($urandom());

    start_i = 1'b1; bin_id_i = WIDTH_BIN_ID'(bin);
    load_lvl_i = ll; base_lvl_i = bl; vs_bin_i = vs; ls_bin_i = ls;
    @(posedge clk); #1;
    // Scramble the request inputs so only latched values can satisfy checks.
    start_i = 1'b0; bin_id_i = ~bin_id_i; load_lvl_i = ~ll; base_lvl_i = ~bl;
    vs_bin_i = ~vs; ls_bin_i = ~ls;
    check("busy_after_start", 256'(busy_o), 256'(1));
    check("results_cleared", 256'({sat_o, unsat_o, bkt_lvl_o, cur_lvl_o}), 256'(0));

    rd_cnt = 0; wr_cnt = 0; cd = 0; last_wr = -100; t_start = -1; n_start = 0;
    pend = 1'b0; finished = 1'b0;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      cmem_valid_i = 1'b0; done_core_i = 1'b0; start_i = 1'b0;

      if (cmem_rd_o) begin
        check("one_outstanding", 256'(pend), 256'(0));
        check("rd_addr", 256'(cmem_addr_o), 256'(bin * NUM_CLAUSES + rd_cnt));
        if (rd_cnt == abort_at) begin
          @(posedge clk); #1;
          rst = 1'b0; #1;
          check_quiet("reset_mid_load");
          #2 rst = 1'b1;
          cmem_valid_i = 1'b1; cmem_data_i = mem[rd_cnt];
          @(posedge clk); #1;
          cmem_valid_i = 1'b0;
          check("stale_valid_ignored",
                256'({|wr_carray_o, |clause_o, busy_o, cmem_rd_o}), 256'(0));
          return;
        end
      end

      if (noise && pend && rd_cnt == 3) begin
        start_i = 1'b1; bin_id_i = WIDTH_BIN_ID'(bin + 1);
      end
      if (noise && pend && rd_cnt == 5) begin
        done_core_i = 1'b1; sat_i = ~e_sat; unsat_i = ~e_unsat;
        bkt_lvl_i = ~e_bkt; cur_lvl_i = ~e_cur;
      end

      if (pend) begin
        if (cd == 0) begin
          cmem_valid_i = 1'b1; cmem_data_i = mem[rd_cnt-1]; pend = 1'b0;
        end else begin
          cd--; cmem_data_i = CW'($urandom());
        end
      end

      if (cmem_rd_o) begin
        if (noise && rd_cnt == 6) begin
          cmem_valid_i = 1'b1; cmem_data_i = CW'($urandom());
        end
        pend = 1'b1; cd = $urandom_range(max_lat, 0); rd_cnt++;
      end

      if (wr_carray_o != '0) begin
        check("wr_row", 256'(wr_carray_o), 256'(1) << wr_cnt);
        check("clause_data", 256'(clause_o), 256'(mem[wr_cnt % NUM_CLAUSES]));
        last_wr = cyc; wr_cnt++;
      end
      if (wr_var_states_o != '0) begin
        check("vs_en", 256'(wr_var_states_o), 256'({NUM_VARS{1'b1}}));
        check("vs_data", 256'(vars_states_o), 256'(vs));
        check("vs_after_rows", 256'(wr_cnt), 256'(NUM_CLAUSES));
        check("vs_timing", 256'(cyc - last_wr), 256'(1));
      end
      if (wr_lvl_states_o != '0) begin
        check("ls_en", 256'(wr_lvl_states_o), 256'({NUM_LVLS{1'b1}}));
        check("ls_data", 256'(lvl_states_o), 256'(ls));
        check("ls_timing", 256'(cyc - last_wr), 256'(2));
      end
      if (start_core_o) begin
        check("start_timing", 256'(cyc - last_wr), 256'(3));
        check("base_lvl_en", 256'(base_lvl_en_o), 256'(1));
        check("cur_bin_num", 256'(cur_bin_num_o), 256'(bin));
        check("load_lvl", 256'(load_lvl_o), 256'(ll));
        check("base_lvl", 256'(base_lvl_o), 256'(bl));
        t_start = cyc; n_start++;
      end
      if (t_start >= 0 && cyc == t_start + done_dly) begin
        check("load_lvl_held", 256'(load_lvl_o), 256'(ll));
        done_core_i = 1'b1; sat_i = e_sat; unsat_i = e_unsat;
        bkt_lvl_i = e_bkt; cur_lvl_i = e_cur;
      end
      if (done_o) begin
        check("done_timing", 256'(cyc - t_start), 256'(done_dly + 1));
        check("busy_at_done", 256'(busy_o), 256'(0));
        check("start_core_count", 256'(n_start), 256'(1));
        check("results", 256'({sat_o, unsat_o, bkt_lvl_o, cur_lvl_o}),
              256'({e_sat, e_unsat, e_bkt, e_cur}));
        finished = 1'b1;
      end
      if (!finished) begin
        @(posedge clk); #1;
      end
    end

    cmem_valid_i = 1'b0; done_core_i = 1'b0; start_i = 1'b0;
    if (!finished) begin
      check("job_timeout", 256'(0), 256'(1));
    end else begin
      @(posedge clk); #1;
      check("done_one_cycle", 256'({done_o, busy_o}), 256'(0));
      check("results_held", 256'({sat_o, unsat_o, bkt_lvl_o, cur_lvl_o}),
            256'({e_sat, e_unsat, e_bkt, e_cur}));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset_state");
    #3 rst = 1'b1;
    @(posedge clk); #1;

    // Stray memory and engine handshakes while idle.
    cmem_valid_i = 1'b1; cmem_data_i = CW'(24'h123456); done_core_i = 1'b1; sat_i = 1'b1;
    @(posedge clk); #1;
    cmem_valid_i = 1'b0; done_core_i = 1'b0; sat_i = 1'b0;
    check("idle_ignores_strays", 256'({busy_o, |wr_carray_o, done_o, sat_o}), 256'(0));

    run_job(3, 1'b0, 0, 1'b0, -1, 1'b1, 1'b0, 16'd4, 16'd2, 10);
    run_job(int'($urandom_range(1023, 0)), 1'b1, 5, 1'b0, -1, 1'b0, 1'b1,
            16'($urandom()), 16'($urandom()), 7);
    run_job(12, 1'b0, 2, 1'b1, -1, 1'b1, 1'b1, 16'h00F0, 16'h0F00, 4);
    run_job(5, 1'b0, 0, 1'b0, 5, 1'b0, 1'b0, 16'd0, 16'd0, 3);
    run_job(5, 1'b0, 3, 1'b0, -1, 1'b1, 1'b0, 16'd9, 16'd11, 6);
    run_job(7, 1'b0, 1, 1'b0, -1, 1'b0, 1'b0, 16'd1, 16'd3, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
